// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit/source-index types and router port numbering.
// No logic; constants only.
// Used by the merge arbiter, its interface and the round-robin picker.
package noc_pkg;

  localparam int FLIT_W    = 11;
  localparam int NUM_PORTS = 5;
  localparam int SRC_W     = 3;
  localparam int CNT_W     = 16;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [SRC_W-1:0]  src_t;

  // Requester numbering on the merge side of a router.
  localparam src_t PORT_N1   = 3'd0;
  localparam src_t PORT_N2   = 3'd1;
  localparam src_t PORT_N3   = 3'd2;
  localparam src_t PORT_N4   = 3'd3;
  localparam src_t PORT_CORE = 3'd4;

endpackage

// File: rtl/big_merge_arbiter_if.sv
// Handshake bundle between the split stage, the merge arbiter and the output link.
// Ports: in_valid/in_data/in_ready (N requesters), out_valid/out_data/out_src/out_ready.
// master = arbiter side, slave = upstream/downstream environment side.
interface big_merge_arbiter_if
  import noc_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int W  = FLIT_W,
  parameter int SW = SRC_W
);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/big_merge_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning upward from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller masks the grant when it cannot accept.
// Ports: req (N-bit requests), ptr (last winner), gnt (one-hot), idx (binary winner), any.
module rr_pick
  import noc_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int SW = SRC_W
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic [SW-1:0] cand;

  // Walking offsets 1..N from ptr is the rotate / priority-encode / rotate-back
  // in one pass; the first hit wins and later hits are ignored.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = SW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/big_merge_arbiter.sv
// Round-robin merge of N requesters onto one output link through a one-entry slot.
// Latency: 1 cycle from input handshake to out_valid; 1 flit/cycle when out_ready=1.
// Backpressure: no grant while the slot holds a flit and out_ready=0; held flit stays stable.
// Ports: CLK, RESET (sync, active-high), bus (master modport of big_merge_arbiter_if),
//        flit_count (accepted flits, wraps), busy (out_valid or any in_valid).
module big_merge_arbiter
  import noc_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int W  = FLIT_W,
  parameter int SW = SRC_W,
  parameter int CW = CNT_W
) (
  input  logic                 CLK,
  input  logic                 RESET,
  big_merge_arbiter_if.master  bus,
  output logic [CW-1:0]        flit_count,
  output logic                 busy
);

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_src_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] rr_ptr;

  logic [N-1:0]  pick_gnt;
  logic [SW-1:0] pick_idx;
  logic          pick_any;
  logic          slot_free;
  logic          grant;
  logic [W-1:0]  sel_data;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req (bus.in_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Slot can take a new flit if empty or being drained this same cycle.
  assign slot_free = !out_valid_q || bus.out_ready;
  // No grant while RESET is high: the flit would be lost by the reset edge.
  assign grant     = slot_free && pick_any && !RESET;

  assign bus.in_ready  = grant ? pick_gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign flit_count    = cnt_q;
  assign busy          = out_valid_q || (|bus.in_valid);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == SW'(i)) begin
        sel_data = bus.in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      cnt_q       <= '0;
      rr_ptr      <= SW'(N-1);   // first scan after reset starts at requester 0
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_src_q   <= pick_idx;
      rr_ptr      <= pick_idx;
      cnt_q       <= cnt_q + CW'(1);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_big_merge_arbiter.sv
module tb_big_merge_arbiter;

  localparam int N  = 5;
  localparam int W  = 11;
  localparam int SW = 3;
  localparam int CW = 4;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  dat;
  } exp_t;

  logic          CLK;
  logic          RESET;
  logic [CW-1:0] flit_count;
  logic          busy;

  big_merge_arbiter_if #(.N(N), .W(W), .SW(SW)) bi ();

  big_merge_arbiter #(.N(N), .W(W), .SW(SW), .CW(CW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bi),
    .flit_count (flit_count),
    .busy       (busy)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  logic [W-1:0] din [N];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_data();
    for (int i = 0; i < N; i++) bi.in_data[i*W +: W] = din[i];
  endtask

  // Monitor: every accepted output flit is popped and compared.
  always @(negedge CLK) begin
    if (!RESET && bi.out_valid === 1'b1 && bi.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: src %0d data 0x%0h with empty scoreboard", bi.out_src, bi.out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_src", 32'(bi.out_src), 32'(e.src));
        chk("out_data", 32'(bi.out_data), 32'(e.dat));
      end
    end
  end

  // One cycle with the given requests; expects requester g to be granted.
  task automatic grant_cycle(input logic [N-1:0] v, input int g, input string nm);
    exp_t e;
    bi.in_valid = v;
    @(negedge CLK);
    chk(nm, 32'(bi.in_ready), 32'(1) << g);
    e.src = SW'(g);
    e.dat = din[g];
    sb_q.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int cycles, input logic [N-1:0] v);
    RESET = 1'b1;
    bi.in_valid = v;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      chk("rst_in_ready", 32'(bi.in_ready), 32'd0);
      if (c > 0) begin
        chk("rst_out_valid", 32'(bi.out_valid), 32'd0);
        chk("rst_flit_count", 32'(flit_count), 32'd0);
      end
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    RESET        = 1'b1;
    bi.in_valid  = '0;
    bi.out_ready = 1'b1;
    for (int i = 0; i < N; i++) din[i] = W'(32'h100 + i);
    apply_data();

    // Reset with all requesters valid, then round-robin rotation.
    do_reset(2, 5'b11111);
    for (int c = 0; c < 10; c++) grant_cycle(5'b11111, c % N, "rr_grant");
    bi.in_valid = '0;
    @(negedge CLK);
    chk("rr_flit_count", 32'(flit_count), 32'd10);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("idle_out_valid", 32'(bi.out_valid), 32'd0);
    @(posedge CLK); #1;

    // Stall: hold 0x102 from requester 2 for four cycles.
    grant_cycle(5'b00100, 2, "stall_setup");
    bi.out_ready = 1'b0;
    bi.in_valid  = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("stall_in_ready", 32'(bi.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bi.out_valid), 32'd1);
      chk("stall_out_data", 32'(bi.out_data), 32'h102);
      chk("stall_out_src", 32'(bi.out_src), 32'd2);
      @(posedge CLK); #1;
    end
    bi.out_ready = 1'b1;
    grant_cycle(5'b11111, 3, "stall_release");
    bi.in_valid = '0;
    @(posedge CLK); #1;

    // Sparse requests with wrap from rr_ptr=3.
    grant_cycle(5'b10010, 4, "sparse_g4a");
    grant_cycle(5'b10010, 1, "sparse_g1");
    grant_cycle(5'b10010, 4, "sparse_g4b");
    bi.in_valid = '0;
    @(negedge CLK);
    chk("sparse_flit_count", 32'(flit_count), 32'd15);
    @(posedge CLK); #1;

    // Counter wrap: 17 back-to-back flits from single requester 2.
    do_reset(2, 5'b00000);
    for (int k = 0; k < 17; k++) begin
      din[2] = W'(32'h200 + k);
      apply_data();
      grant_cycle(5'b00100, 2, "wrap_grant");
    end
    bi.in_valid = '0;
    @(negedge CLK);
    chk("wrap_flit_count", 32'(flit_count), 32'd1);
    @(posedge CLK); #1;

    // Reset mid-operation while holding 0x7FF.
    din[0] = 11'h7FF;
    apply_data();
    grant_cycle(5'b00001, 0, "mid_setup");
    RESET        = 1'b1;
    bi.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) din[i] = W'(32'h300 + i);
    apply_data();
    bi.in_valid = 5'b00111;
    @(negedge CLK);
    chk("mid_rst_in_ready", 32'(bi.in_ready), 32'd0);
    chk("mid_rst_held", 32'(bi.out_valid), 32'd1);
    @(posedge CLK); #1;
    sb_q.delete();   // held flit is discarded by reset, never delivered
    RESET        = 1'b0;
    bi.out_ready = 1'b1;
    begin
      exp_t e;
      @(negedge CLK);
      chk("mid_out_valid", 32'(bi.out_valid), 32'd0);
      chk("mid_out_data", 32'(bi.out_data), 32'd0);
      chk("mid_out_src", 32'(bi.out_src), 32'd0);
      chk("mid_g0", 32'(bi.in_ready), 32'b00001);
      e.src = 3'd0;
      e.dat = din[0];
      sb_q.push_back(e);
      @(posedge CLK); #1;
    end
    grant_cycle(5'b00110, 1, "mid_g1");
    grant_cycle(5'b00100, 2, "mid_g2");
    bi.in_valid = '0;

    w = 0;
    while (sb_q.size() != 0 && w < 20) begin
      @(posedge CLK); #1;
      w++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    @(negedge CLK);
    chk("final_flit_count", 32'(flit_count), 32'd3);
    chk("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
